// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 style exception unit: COUNT/COMPARE timer, STATUS/CAUSE/EPC
// registers and a three-state take/handler/return sequencer.
module cp0_exception_unit #(
   parameter int          NUM_INT  = 6,
   parameter int          NUM_TRAP = 2,
   parameter logic [31:0] VEC0     = 32'h0000_0180,
   parameter logic [31:0] VEC1     = 32'h0000_0200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [4:0]          addr,
   input  logic [31:0]         wd,
   output logic [31:0]         rd,
   input  logic [NUM_INT-1:0]  int_in,
   input  logic [NUM_TRAP-1:0] trap_in,
   input  logic [31:0]         pc_ret,
   input  logic                eret,
   output logic                exc_take,
   output logic [31:0]         exc_vector,
   output logic                exl,
   output logic [31:0]         epc
);

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_STATUS  = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;
   localparam int         INT_LSB   = 8 + NUM_TRAP;
   localparam logic [4:0] EXC_TRAP  = 5'b01101;

   typedef enum logic [1:0] {S_IDLE, S_TAKE, S_HANDLER} state_t;

   state_t              state_q, state_d;
   logic [31:0]         count_q, compare_q, epc_q;
   logic                ie_q, iv_q, timer_pend_q;
   logic [NUM_TRAP-1:0] trap_en_q, trap_pend_q;
   logic [NUM_INT-1:0]  int_mask_q, int_pend_q, int_pend_vis;
   logic [4:0]          exc_code_q;
   logic [31:0]         status_rd, cause_rd;
   logic                wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic                any_pend, take;

   assign wr_count   = we && (addr == A_COUNT);
   assign wr_compare = we && (addr == A_COMPARE);
   assign wr_status  = we && (addr == A_STATUS);
   assign wr_cause   = we && (addr == A_CAUSE);
   assign wr_epc     = we && (addr == A_EPC);

   // The timer request shares the highest interrupt line without being masked.
   always_comb begin
      int_pend_vis              = int_pend_q;
      int_pend_vis[NUM_INT-1]   = int_pend_q[NUM_INT-1] | timer_pend_q;
   end

   assign any_pend = (|trap_pend_q) || (|int_pend_vis);
   assign take     = (state_q == S_IDLE) && ie_q && any_pend;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (take) state_d = S_TAKE;
         S_TAKE:    state_d = S_HANDLER;
         S_HANDLER: if (eret) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is only ever assigned with non-blocking <=.
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q      <= '0;
         compare_q    <= '0;
         epc_q        <= '0;
         ie_q         <= 1'b0;
         iv_q         <= 1'b0;
         timer_pend_q <= 1'b0;
         trap_en_q    <= '0;
         trap_pend_q  <= '0;
         int_mask_q   <= '0;
         int_pend_q   <= '0;
         exc_code_q   <= '0;
      end else begin
         count_q <= wr_count ? wd : count_q + 32'd1;
         if (wr_compare) compare_q <= wd;
         if (wr_compare)                  timer_pend_q <= 1'b0;
         else if (count_q == compare_q)   timer_pend_q <= 1'b1;
         if (wr_status) begin
            ie_q       <= wd[0];
            trap_en_q  <= wd[8 +: NUM_TRAP];
            int_mask_q <= wd[INT_LSB +: NUM_INT];
         end
         if (wr_cause) iv_q <= wd[23];
         // Software may only clear trap bits; a hardware set in the same cycle wins.
         trap_pend_q <= (wr_cause ? (trap_pend_q & wd[8 +: NUM_TRAP]) : trap_pend_q)
                        | (trap_in & trap_en_q);
         int_pend_q  <= int_in & int_mask_q;
         if (take) begin
            epc_q      <= pc_ret;
            exc_code_q <= (|trap_pend_q) ? EXC_TRAP : 5'b00000;
         end else if (wr_epc) begin
            epc_q <= wd;
         end
      end
   end

   assign exl        = (state_q != S_IDLE);
   assign exc_take   = (state_q == S_TAKE);
   assign epc        = epc_q;
   assign exc_vector = iv_q ? VEC1 : VEC0;

   always_comb begin
      status_rd                       = '0;
      status_rd[0]                    = ie_q;
      status_rd[1]                    = exl;
      status_rd[8 +: NUM_TRAP]        = trap_en_q;
      status_rd[INT_LSB +: NUM_INT]   = int_mask_q;
   end

   always_comb begin
      cause_rd                        = '0;
      cause_rd[23]                    = iv_q;
      cause_rd[8 +: NUM_TRAP]         = trap_pend_q;
      cause_rd[INT_LSB +: NUM_INT]    = int_pend_vis;
      cause_rd[6:2]                   = exc_code_q;
   end

   always_comb begin
      case (addr)
         A_COUNT:   rd = count_q;
         A_COMPARE: rd = compare_q;
         A_STATUS:  rd = status_rd;
         A_CAUSE:   rd = cause_rd;
         A_EPC:     rd = epc_q;
         default:   rd = '0;
      endcase
   end

endmodule
